// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the registered ripple adder.
// Imported by the half-adder cell and the adder top level.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  // Width of {cout, sum}: one carry bit above the operands.
  function automatic int res_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/full_adder_ha_46_half_adder.sv
// Single-bit half adder, the building block of the adder cell.
// Ports: x, y operands -> s = x ^ y, c = x & y.
module half_adder
  import full_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_adder_ha_46.sv
// Registered WIDTH-bit ripple adder; each bit is two half adders plus OR.
// Ports: clk, rst (async high), in_valid, a, b, cin -> sum, cout, out_valid.
module full_adder_ha_46
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int RW = res_width(WIDTH);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder_ha_46: WIDTH out of range");
  end

  logic [RW-1:0]    c;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] g2;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha1 (
      .x (a[i]),
      .y (b[i]),
      .s (p[i]),
      .c (g1[i])
    );
    half_adder u_ha2 (
      .x (p[i]),
      .y (c[i]),
      .s (s[i]),
      .c (g2[i])
    );
    // g1 and g2 are never both set, so OR is the carry merge.
    assign c[i+1] = g1[i] | g2[i];
  end

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;
  logic             valid_d;
  logic             valid_q;

  // Result registers only load on a valid beat; valid itself
  // tracks in_valid every cycle so stale data reads as not fresh.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[RW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_ha_46.sv
// Directed and random checks of full_adder_ha_46 at WIDTH=1 and WIDTH=8.
// Expected values come from a hand-filled table and a+b+cin arithmetic.
module tb_full_adder_ha_46;

  logic       clk;
  logic       rst;

  logic       v1;
  logic       a1, b1, c1;
  logic       s1, co1, ov1;

  logic       v8;
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] s8;
  logic       co8, ov8;

  int passed;
  int total;

  full_adder_ha_46 #(.WIDTH(1)) u_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v1),
    .a         (a1),
    .b         (b1),
    .cin       (c1),
    .sum       (s1),
    .cout      (co1),
    .out_valid (ov1)
  );

  full_adder_ha_46 #(.WIDTH(8)) u_w8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .a         (a8),
    .b         (b8),
    .cin       (c8),
    .sum       (s8),
    .cout      (co8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic ci;
    logic s;
    logic co;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] exp9;

  initial begin
    passed = 0;
    total  = 0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    step();
    step();
    chk("rst_sum1",  {63'd0, s1},  64'd0);
    chk("rst_cout1", {63'd0, co1}, 64'd0);
    chk("rst_ov1",   {63'd0, ov1}, 64'd0);
    chk("rst_sum8",  {56'd0, s8},  64'd0);
    chk("rst_ov8",   {63'd0, ov8}, 64'd0);
    rst = 1'b0;

    // exhaustive WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1;
      a1 = tbl[i].a;
      b1 = tbl[i].b;
      c1 = tbl[i].ci;
      step();
      chk($sformatf("tt%0d_sum", i),  {63'd0, s1},  {63'd0, tbl[i].s});
      chk($sformatf("tt%0d_cout", i), {63'd0, co1}, {63'd0, tbl[i].co});
      chk($sformatf("tt%0d_ov", i),   {63'd0, ov1}, 64'd1);
    end

    // asynchronous reset mid-stream
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    step();
    chk("pre_rst_sum",  {63'd0, s1},  64'd1);
    chk("pre_rst_cout", {63'd0, co1}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum",  {63'd0, s1},  64'd0);
    chk("async_rst_cout", {63'd0, co1}, 64'd0);
    chk("async_rst_ov",   {63'd0, ov1}, 64'd0);
    #1 rst = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    step();
    chk("post_rst_sum",  {63'd0, s1},  64'd1);
    chk("post_rst_cout", {63'd0, co1}, 64'd0);
    chk("post_rst_ov",   {63'd0, ov1}, 64'd1);

    // hold when in_valid is low
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    step();
    chk("load_sum", {63'd0, s1}, 64'd1);
    v1 = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    step();
    chk("hold_sum",  {63'd0, s1},  64'd1);
    chk("hold_cout", {63'd0, co1}, 64'd0);
    chk("hold_ov",   {63'd0, ov1}, 64'd0);

    // WIDTH=8 carry ripple through every bit
    v8 = 1'b1;
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    step();
    chk("rip1_sum",  {56'd0, s8},  64'h00);
    chk("rip1_cout", {63'd0, co8}, 64'd1);
    chk("rip1_ov",   {63'd0, ov8}, 64'd1);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    step();
    chk("rip2_sum",  {56'd0, s8},  64'hFF);
    chk("rip2_cout", {63'd0, co8}, 64'd1);

    // WIDTH=8 back-to-back random
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
      step();
      chk($sformatf("rnd%0d_res", i), {55'd0, co8, s8}, {55'd0, exp9});
      chk($sformatf("rnd%0d_ov", i),  {63'd0, ov8},     64'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/full_adder_ha_46.md
Name: full_adder_ha_46

Overview:
- Registered full adder whose adder cell is built from two half adders and an OR gate.
- Parameterised to WIDTH bits as a ripple chain of those cells. WIDTH=1 gives the classic single-bit a/b/cin -> sum/cout adder.
- Serves as the leaf arithmetic primitive for datapath blocks that need a pipelined add with carry-in and carry-out.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  a/b/cin are sampled at this rising edge
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in to bit 0
- sum  output  WIDTH  registered sum bits
- cout  output  1  registered carry-out of bit WIDTH-1
- out_valid  output  1  sum/cout hold a fresh result

Behaviour:
- Reset is asynchronous and active-high. While rst=1: sum=0, cout=0, out_valid=0, immediately and independent of clk.
- Adder cell, bit i:
  - half adder 1: p = a[i]^b[i], g1 = a[i]&b[i]
  - half adder 2: s = p^c[i], g2 = p&c[i]
  - outputs: sum bit s; carry c[i+1] = g1|g2
  - c[0] = cin; cout = c[WIDTH]
- Arithmetic: {cout,sum} equals a + b + cin, computed at WIDTH+1 bits with no truncation. Wrap-around example: all-ones + 0 + 1 -> sum=0, cout=1.
- Latency is exactly 1 clock. On a rising edge with in_valid=1, the combinational result is captured into sum/cout and out_valid is set to 1.
- On a rising edge with in_valid=0:
  - sum/cout hold their previous values;
  - out_valid is cleared to 0.
- Throughput is one result per clock. Back-to-back in_valid=1 yields a new result every cycle. There is no backpressure and no ready signal.
- Reset asserted mid-stream clears all outputs at once. The first edge after rst falls with in_valid=1 produces a valid result; there is no recovery latency.
- No combinational path from any input to any output; all outputs come straight from flops.
- Unknown (X) inputs are not filtered. A clean reset leaves outputs 0.

Decomposition:
- Shared package full_adder_pkg:
  - MAX_WIDTH = 64
  - localparam-style helper for the result width, WIDTH+1
- Sub-module half_adder with ports x, y -> s, c (s = x^y, c = x&y).
  - Instantiated twice per bit inside a generate loop.
  - No separate full-adder cell module; the OR and the chaining live in the generate body.
- The top level holds the generate chain plus the output register stage.

Test Plan:
- WIDTH=1, exhaustive. Drive {a,b,cin} = 0..7 with in_valid=1, one vector per clock, 10 ns clock. One cycle after each vector the outputs must be:
  - 000 -> sum=0, cout=0
  - 001 -> sum=1, cout=0
  - 010 -> sum=1, cout=0
  - 011 -> sum=0, cout=1
  - 100 -> sum=1, cout=0
  - 101 -> sum=0, cout=1
  - 110 -> sum=0, cout=1
  - 111 -> sum=1, cout=1
  - out_valid=1 throughout.
- Reset: after loading a=1, b=1, cin=1 (sum=1, cout=1), assert rst between edges -> sum=0, cout=0, out_valid=0 before the next clk edge. Release rst and apply a=1, b=0, cin=0 -> sum=1, cout=0, out_valid=1 one cycle later.
- Hold: load a=0, b=1, cin=0, then drive in_valid=0 with a=1, b=1, cin=1 -> sum stays 1, cout stays 0, out_valid drops to 0.
- WIDTH=8 carry ripple: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- WIDTH=8 random: 1000 back-to-back random vectors -> each cycle, {cout,sum} equals the previous cycle's a+b+cin, and out_valid=1 every cycle.
